pipeline_hazard_controller: RTL and testbench

Central stall/nullify sequencer for the five-stage MIPS pipeline. Drives the `stall` and `nullify` inputs of the four inter-stage pipeline registers and the PC register. It resolves load-use hazards, wrong-path fetches after taken branches/jumps, HI/LO interlocks against the multi-cycle multiply/divide unit, and full flushes on exceptions raised in the memory stage. It sits beside the datapath and holds the only state governing pipeline flow.

---
 rtl/pipeline_hazard_controller.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/nullify sequencer for the five-stage pipeline: load-use, branch, HI/LO and exception flush control.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_controller #(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_uses_rs,
    input  logic        d_uses_rt,
    input  logic        d_uses_hilo,
    input  logic [4:0]  e_dest_reg,
    input  logic        e_mem_read,
    input  logic        e_branch_taken,
    input  logic        e_muldiv_start,
    input  logic        m_exception,
    output logic        pc_stall,
    output logic [3:0]  stall,
    output logic [3:0]  nullify,
    output logic        hilo_busy,
    output logic        muldiv_abort
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULDIV_WAIT = 2'd1,
        FLUSH       = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_c;
    logic               load_use_c;
    logic               hilo_haz_c;
    logic               flush_c;

    // Next-state: an exception pre-empts everything and cancels any pending mul/div.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_c = 1'b0;
        if (m_exception) begin
            state_d = FLUSH;
            cnt_d   = '0;
            abort_c = (state_q == MULDIV_WAIT);
        end else begin
            case (state_q)
                RUN: begin
                    if (e_muldiv_start) begin
                        state_d = MULDIV_WAIT;
                        cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                    end
                end
                MULDIV_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load_use_c = e_mem_read && (e_dest_reg != 5'd0) &&
                        ((d_uses_rs && (d_rs == e_dest_reg)) ||
                         (d_uses_rt && (d_rt == e_dest_reg)));
    assign hilo_haz_c = d_uses_hilo && (state_q == MULDIV_WAIT);
    assign flush_c    = m_exception || (state_q == FLUSH);

    // Pipeline control, prioritised; everything is held low while reset is asserted.
    always_comb begin
        pc_stall     = 1'b0;
        stall        = 4'b0000;
        nullify      = 4'b0000;
        hilo_busy    = 1'b0;
        muldiv_abort = 1'b0;
        if (!reset) begin
            hilo_busy    = (state_q == MULDIV_WAIT);
            muldiv_abort = abort_c;
            if (flush_c) begin
                nullify = 4'b1111;
            end else if (e_branch_taken) begin
                nullify = 4'b0001;
            end else if (load_use_c || hilo_haz_c) begin
                pc_stall = 1'b1;
                stall    = 4'b0001;
                nullify  = 4'b0010;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    // A flush that is extended by a back-to-back exception counts as one entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((state_d == FLUSH) && (state_q != FLUSH)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller with an independent cycle model (MULDIV_CYCLES=4).
module tb_pipeline_hazard_controller;

    localparam int unsigned MD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_dest_reg;
    logic        d_uses_rs, d_uses_rt, d_uses_hilo;
    logic        e_mem_read, e_branch_taken, e_muldiv_start, m_exception;
    logic        pc_stall, hilo_busy, muldiv_abort;
    logic [3:0]  stall, nullify;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipeline_hazard_controller #(.MULDIV_CYCLES(MD)) dut (
        .clk            (clk),
        .reset          (reset),
        .d_rs           (d_rs),
        .d_rt           (d_rt),
        .d_uses_rs      (d_uses_rs),
        .d_uses_rt      (d_uses_rt),
        .d_uses_hilo    (d_uses_hilo),
        .e_dest_reg     (e_dest_reg),
        .e_mem_read     (e_mem_read),
        .e_branch_taken (e_branch_taken),
        .e_muldiv_start (e_muldiv_start),
        .m_exception    (m_exception),
        .pc_stall       (pc_stall),
        .stall          (stall),
        .nullify        (nullify),
        .hilo_busy      (hilo_busy),
        .muldiv_abort   (muldiv_abort)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected {pc_stall, stall, nullify, hilo_busy, muldiv_abort}
    logic [10:0] exp_q[$];

    int    m_busy_left = 0;
    bit    m_flush     = 1'b0;
    int    m_stalls    = 0;
    int    m_flushes   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        d_rs = 5'd0; d_rt = 5'd0; d_uses_rs = 1'b0; d_uses_rt = 1'b0; d_uses_hilo = 1'b0;
        e_dest_reg = 5'd0; e_mem_read = 1'b0; e_branch_taken = 1'b0;
        e_muldiv_start = 1'b0; m_exception = 1'b0;
    endtask

    // Inputs are already driven; model the cycle, push the expectation, compare at negedge.
    task automatic step(input string tag);
        logic [10:0] e;
        logic [10:0] got;
        bit busy, lu, hz, fl, ps;
        logic [3:0] st, nu;
        busy = (m_busy_left > 0);
        lu = e_mem_read && (e_dest_reg != 0) &&
             ((d_uses_rs && d_rs == e_dest_reg) || (d_uses_rt && d_rt == e_dest_reg));
        hz = d_uses_hilo && busy;
        fl = m_exception || m_flush;
        ps = 1'b0; st = 4'h0; nu = 4'h0;
        if (fl)                   nu = 4'hF;
        else if (e_branch_taken)  nu = 4'h1;
        else if (lu || hz) begin  ps = 1'b1; st = 4'h1; nu = 4'h2; end
        if (reset) e = '0;
        else       e = {ps, st, nu, busy, m_exception && busy};
        exp_q.push_back(e);

        @(negedge clk);
        got = {pc_stall, stall, nullify, hilo_busy, muldiv_abort};
        check_val(tag, 64'(got), 64'(exp_q.pop_front()));
`ifdef HAZARD_STATS_EN
        check_val({tag, "_stallcnt"}, 64'(stall_cycles), 64'(m_stalls));
        check_val({tag, "_flushcnt"}, 64'(flush_count), 64'(m_flushes));
`endif
        if (reset) begin
            m_busy_left = 0; m_flush = 1'b0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (ps) m_stalls++;
            if (m_exception && !m_flush) m_flushes++;
            if (m_exception) begin
                m_busy_left = 0;
            end else if (!m_flush) begin
                if (busy)                m_busy_left--;
                else if (e_muldiv_start) m_busy_left = MD;
            end
            m_flush = m_exception;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_rs(input logic [4:0] r, input string tag);
        set_idle(); e_mem_read = 1'b1; e_dest_reg = r; d_uses_rs = 1'b1; d_rs = r;
        step(tag);
        set_idle(); d_uses_rs = 1'b1; d_rs = r;
        step({tag, "_after"});
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        step("reset_hold");
        step("reset_hold2");
        reset = 1'b0;
        set_idle(); step("idle");

        load_use_rs(5'd5, "lu_rs_r5");
        set_idle(); e_mem_read = 1'b1; e_dest_reg = 5'd0; d_uses_rs = 1'b1; d_rs = 5'd0;
        step("lu_r0");
        set_idle(); e_mem_read = 1'b1; e_dest_reg = 5'd9; d_uses_rt = 1'b1; d_rt = 5'd9;
        step("lu_rt_r9");
        set_idle(); e_mem_read = 1'b1; e_dest_reg = 5'd9; d_uses_rs = 1'b0; d_rs = 5'd9;
        step("lu_unused_rs");
        set_idle(); e_mem_read = 1'b1; e_dest_reg = 5'd7; d_uses_rs = 1'b1; d_rs = 5'd7;
        e_branch_taken = 1'b1;
        step("branch_over_lu");

        // Mul/div start with a held HI/LO reader, then a clean window.
        set_idle(); e_muldiv_start = 1'b1; step("md_start");
        set_idle(); d_uses_hilo = 1'b1;
        for (int i = 0; i < MD + 2; i++) step("md_hilo_wait");

        // Exception during the busy window cancels the mul/div.
        set_idle(); e_muldiv_start = 1'b1; step("md_start2");
        set_idle(); d_uses_hilo = 1'b1; step("md_busy2");
        m_exception = 1'b1; step("md_exc");
        m_exception = 1'b0; step("md_flush");
        step("md_after_flush");

        // Reset mid-window, then a fresh full window.
        set_idle(); e_muldiv_start = 1'b1; step("md_start3");
        set_idle(); step("md_busy3");
        reset = 1'b1; step("md_reset");
        reset = 1'b0; step("post_reset");
        e_muldiv_start = 1'b1; step("md_start4");
        set_idle();
        for (int i = 0; i < MD + 1; i++) step("md_window4");

        // Back-to-back exceptions, branch during flush.
        m_exception = 1'b1; step("exc_a");
        step("exc_b");
        m_exception = 1'b0; e_branch_taken = 1'b1; step("flush_vs_branch");
        set_idle(); step("idle2");

        // Stats scenario: three load-use stalls and two exceptions after a clean reset.
        reset = 1'b1; step("stats_reset");
        reset = 1'b0;
        load_use_rs(5'd3, "st_lu1");
        load_use_rs(5'd4, "st_lu2");
        set_idle(); m_exception = 1'b1; step("st_exc1");
        set_idle(); step("st_flush1");
        load_use_rs(5'd6, "st_lu3");
        m_exception = 1'b1; step("st_exc2");
        set_idle(); step("st_flush2");
        step("st_idle");
`ifdef HAZARD_STATS_EN
        check_val("stats_stall_cycles", 64'(stall_cycles), 64'd3);
        check_val("stats_flush_count", 64'(flush_count), 64'd2);
`endif

        // Random traffic over a small register range to provoke frequent hits.
        for (int i = 0; i < 200; i++) begin
            d_rs           = 5'($urandom_range(0, 3));
            d_rt           = 5'($urandom_range(0, 3));
            e_dest_reg     = 5'($urandom_range(0, 3));
            d_uses_rs      = 1'($urandom_range(0, 1));
            d_uses_rt      = 1'($urandom_range(0, 1));
            d_uses_hilo    = 1'($urandom_range(0, 1));
            e_mem_read     = 1'($urandom_range(0, 1));
            e_branch_taken = ($urandom_range(0, 5) == 0);
            e_muldiv_start = ($urandom_range(0, 4) == 0);
            m_exception    = ($urandom_range(0, 12) == 0);
            reset          = ($urandom_range(0, 40) == 0);
            step("random");
        end
        reset = 1'b0;
        set_idle();

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
